dff_stream_deserializer: RTL
============================

// Module: dff_stream_deserializer
// PURPOSE
//  Consumes the registered serial bit stream from the D flip-flop stage (its q output).
//  Packs the bits into WIDTH-bit parallel words.
//  Presents each word on a valid/ready output port with a one-word holding register.
//  Words that arrive while the holding register is blocked are counted and flagged, not stalled.
// PARAMETERS
//  WIDTH      8   bits per output word (>=2)
//  MSB_FIRST  0   0: first received bit lands in word_out[0]; 1: first bit lands in word_out[WIDTH-1]
//  CNT_W      8   width of the dropped-word counter
// PORTS
//  clk         in   1      rising-edge clock shared with the flip-flop stage
//  rst         in   1      asynchronous reset, active-low (0 = reset)
//  bit_in      in   1      serial data from the flip-flop q
//  bit_valid   in   1      bit_in is sampled on this edge when 1
//  clear       in   1      synchronous flush: discard partial word and held word; clear overflow and drop_cnt
//  word_out    out  WIDTH  assembled word, stable while word_valid=1
//  word_valid  out  1      holding register full
//  word_ready  in   1      consumer accepts word_out on an edge where word_valid&&word_ready
//  bit_cnt     out  $clog2(WIDTH)  bits of the current partial word already captured
//  overflow    out  1      sticky: at least one completed word was dropped
//  drop_cnt    out  CNT_W  number of dropped words, saturates at all-ones
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - shift register, word_out, bit_cnt, word_valid, overflow and drop_cnt all go to 0 immediately.
//   - Any partial or held word is lost; no output is produced from pre-reset bits.
//   - Operation resumes on the first rising edge after rst=1.
//  Assembly:
//   - On each edge with bit_valid=1, bit_in is shifted in per MSB_FIRST and bit_cnt increments.
//   - At bit_cnt==WIDTH-1, that edge completes the word and bit_cnt wraps to 0.
//   - bit_valid=0 holds bit_cnt and the partial word (gaps are allowed).
//  Holding register, states EMPTY / FULL (word_valid = FULL):
//   - EMPTY + completing edge -> FULL; word_out loads the word.
//     word_valid rises on the same edge the last bit is captured (visible the cycle after the last bit is presented).
//   - FULL + word_ready=1, no completing edge -> EMPTY.
//   - FULL + word_ready=1 + completing edge on the same edge -> stays FULL; word_out loads the new word (no bubble, no drop).
//   - FULL + word_ready=0 + completing edge -> stays FULL; word_out unchanged; new word dropped;
//     overflow<=1; drop_cnt<=drop_cnt+1 unless already all-ones.
//   - word_out must not change while word_valid=1 && word_ready=0.
//  Clear:
//   - Edge with clear=1: bit_cnt<=0, word_valid<=0, overflow<=0, drop_cnt<=0.
//   - clear has priority over bit_valid and word_ready on that edge; that edge's bit is discarded.
//  Latency: one clock from the last bit presented to word_valid=1.
//  Throughput: one word per WIDTH valid bits, sustained when word_ready is held at 1.
// TESTING (WIDTH=8 unless noted)
//  1. Reset then bits 1,0,1,1,0,0,1,0 on consecutive edges, word_ready=1, MSB_FIRST=0
//     -> word_out=8'h4D, word_valid for exactly 1 cycle, bit_cnt returns to 0.
//  2. Same bits with MSB_FIRST=1 -> word_out=8'hB2.
//  3. word_ready=0, stream 3 words (A5,3C,FF)
//     -> word_out stays A5, overflow=1, drop_cnt=2.
//     Then word_ready=1 for one edge -> word_valid=0.
//  4. Back-to-back words with word_ready pulsed only on the completing edge of word 2
//     -> word 2 replaces word 1, word_valid stays 1, drop_cnt=0.
//  5. Assert rst=0 mid-clock after 5 bits
//     -> all outputs 0 before the next edge.
//     After release, 8 new bits 0xF0 (LSB first) -> word_out=8'hF0, no stale bits.
//  6. Hold bit_valid=0 for 10 cycles mid-word and pulse clear with bit_valid=1
//     -> partial word discarded, bit_cnt=0, overflow and drop_cnt cleared.
//     Bench also runs 300 drops with CNT_W=8 -> drop_cnt saturates at 255.

Source files
------------

// File: rtl/dff_stream_deserializer.sv
// Serial-to-parallel deserializer fed by a D flip-flop stage. Valid bits are
// packed into WIDTH-bit words and offered on a valid/ready port backed by a
// single holding register. A word that completes while the holding register
// is full and not being accepted is dropped, counted and flagged.
module dff_stream_deserializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  input  logic                     clear,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_t;

  hold_state_t      state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q,  word_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             ovf_q,   ovf_d;
  logic [CNT_W-1:0] drop_q,  drop_d;

  logic [WIDTH-1:0] assembled;
  logic             complete;

  // Shift register contents after accepting bit_in, in the configured order.
  always_comb begin
    if (MSB_FIRST) begin
      assembled = {shift_q[WIDTH-2:0], bit_in};
    end else begin
      assembled = {bit_in, shift_q[WIDTH-1:1]};
    end
    complete = bit_valid && (cnt_q == CW'(WIDTH - 1));
  end

  // Next-state for assembly, holding register FSM and drop bookkeeping.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;

    if (clear) begin
      // Stale bits left in shift_q are harmless: a fresh word shifts in
      // WIDTH new bits before it is ever presented.
      state_d = EMPTY;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      drop_d  = '0;
    end else begin
      if (bit_valid) begin
        shift_d = assembled;
        cnt_d   = complete ? '0 : cnt_q + CW'(1);
      end

      unique case (state_q)
        EMPTY: begin
          if (complete) begin
            state_d = FULL;
            word_d  = assembled;
          end
        end
        FULL: begin
          if (complete && word_ready) begin
            word_d = assembled;
          end else if (complete) begin
            ovf_d = 1'b1;
            if (drop_q != '1) begin
              drop_d = drop_q + CNT_W'(1);
            end
          end else if (word_ready) begin
            state_d = EMPTY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      shift_q <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = (state_q == FULL);
  assign bit_cnt    = cnt_q;
  assign overflow   = ovf_q;
  assign drop_cnt   = drop_q;

endmodule
